// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 parallel bus writer.
package hd44780_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    E_LOW,
    WAIT
  } state_t;

  // Which half of the byte is on DB[7:4] in 4-bit mode.
  typedef enum logic {
    NIB_HIGH,
    NIB_LOW
  } nib_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear-display and return-home (0x02/0x03) instructions need the long hold-off.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == (CMD_HOME | CMD_CLEAR)));
  endfunction

endpackage

// File: rtl/hd44780_bus_writer_if.sv
// Byte handshake plus HD44780 pin group for the bus writer.
interface hd44780_bus_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_ready;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;

  modport master (
    output in_valid, in_data, in_rs,
    input  in_ready, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  modport slave (
    input  in_valid, in_data, in_rs,
    output in_ready, lcd_rs, lcd_rw, lcd_e, lcd_db
  );
endinterface

// File: rtl/hd44780_tick_edge.sv
// Rising-edge detector for the divided LCD clock; tick is one clk wide.
module hd44780_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic clkdvd,
  output logic tick
);

  logic clkdvd_q;

  // History register for the divided clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clkdvd_q <= 1'b0;
    else      clkdvd_q <= clkdvd;
  end

  assign tick = clkdvd & ~clkdvd_q;

endmodule

// File: rtl/hd44780_bus_writer.sv
// HD44780 bus writer: one byte per handshake, setup / E pulse / hold phases
// stepped on rising edges of clkdvd, then an execution-time hold-off.
// Build option: define HD44780_4BIT_EN for the 4-bit bus (two nibbles on DB[7:4]).
//
// state  | meaning
// IDLE   | in_ready high, waiting for a byte
// SETUP  | RS/DB driven, E low, waiting for the tick that raises E
// E_HIGH | E high for one clkdvd period
// E_LOW  | E low, RS/DB held; next tick sends low nibble or starts hold-off
// WAIT   | hold-off counter running down on ticks
module hd44780_bus_writer
  import hd44780_pkg::*;
#(
  parameter int WAIT_TICKS      = 40,
  parameter int LONG_WAIT_TICKS = 1600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkdvd,
  hd44780_bus_writer_if.slave   bus
);

`ifdef HD44780_4BIT_EN
  localparam bit FOUR_BIT = 1'b1;
`else
  localparam bit FOUR_BIT = 1'b0;
`endif
  localparam int CW = $clog2(LONG_WAIT_TICKS + 1);

  logic          tick;
  state_t        state_q, state_d;
  nib_t          nib_q, nib_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic          e_q, e_d;
  logic          ready_q, ready_d;

  hd44780_tick_edge u_tick (
    .clk    (clk),
    .rst    (rst),
    .clkdvd (clkdvd),
    .tick   (tick)
  );

  // State and registered bus outputs; reset drops E immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      nib_q   <= NIB_HIGH;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      e_q     <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      e_q     <= e_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and next-output decode; only acceptance ignores the tick.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    db_d    = db_q;
    e_d     = e_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          data_d  = bus.in_data;
          rs_d    = bus.in_rs;
          db_d    = FOUR_BIT ? {bus.in_data[7:4], 4'h0} : bus.in_data;
          nib_d   = NIB_HIGH;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          e_d     = 1'b1;
          state_d = E_HIGH;
        end
      end
      E_HIGH: begin
        if (tick) begin
          e_d     = 1'b0;
          state_d = E_LOW;
        end
      end
      E_LOW: begin
        if (tick) begin
          if (FOUR_BIT && nib_q == NIB_HIGH) begin
            nib_d   = NIB_LOW;
            db_d    = {data_q[3:0], 4'h0};
            state_d = SETUP;
          end else begin
            cnt_d   = is_long_cmd(rs_q, data_q) ? CW'(LONG_WAIT_TICKS) : CW'(WAIT_TICKS);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (tick) begin
          // A loaded count of 0 behaves like 1: the hold-off is never shorter than one tick.
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            db_d    = '0;
            rs_d    = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = ready_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_db   = db_q;

endmodule

// File: tb/tb_hd44780_bus_writer.sv
// Bench for hd44780_bus_writer: tick-count model of the bus waveform plus
// directed writes with hand-computed tick budgets and bus contents.
module tb_hd44780_bus_writer;

  localparam int WT  = 3;
  localparam int LWT = 20;
`ifdef HD44780_4BIT_EN
  localparam bit FOUR = 1'b1;
`else
  localparam bit FOUR = 1'b0;
`endif
  localparam int PH = FOUR ? 2 : 1;   // E pulses per byte
  localparam int DIV_HALF = 4;        // clk cycles per clkdvd half period

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clkdvd = 1'b0;

  hd44780_bus_writer_if bus_if();

  hd44780_bus_writer #(.WAIT_TICKS(WT), .LONG_WAIT_TICKS(LWT)) dut (
    .clk    (clk),
    .rst    (rst),
    .clkdvd (clkdvd),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Divided clock source, stepped just after clk edges.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      if (c == DIV_HALF) begin
        c = 0;
        clkdvd = ~clkdvd;
      end
    end
  end

  // ---------------- model: a write is a count of ticks since accept ----------------
  logic       m_prev;
  logic       m_busy;
  int         m_k;
  logic [7:0] m_d;
  logic       m_rs;
  int         n_ticks = 0;

  function automatic int hold_of(input logic [7:0] d, input logic rs);
    int h;
    h = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LWT : WT;
    return (h < 1) ? 1 : h;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prev <= 1'b0;
      m_busy <= 1'b0;
      m_k    <= 0;
      m_d    <= '0;
      m_rs   <= 1'b0;
    end else begin
      m_prev <= clkdvd;
      if (clkdvd && !m_prev) n_ticks <= n_ticks + 1;
      if (!m_busy) begin
        if (bus_if.in_valid) begin
          m_busy <= 1'b1;
          m_k    <= 0;
          m_d    <= bus_if.in_data;
          m_rs   <= bus_if.in_rs;
        end
      end else if (clkdvd && !m_prev) begin
        m_k <= m_k + 1;
        if (m_k + 1 == 3 * PH + hold_of(m_d, m_rs)) m_busy <= 1'b0;
      end
    end
  end

  logic       x_rdy, x_e, x_rs;
  logic [7:0] x_db;
  int         x_nib;

  always_comb begin
    x_rdy = 1'b1;
    x_e   = 1'b0;
    x_rs  = 1'b0;
    x_db  = '0;
    x_nib = 0;
    if (m_busy) begin
      x_rdy = 1'b0;
      x_rs  = m_rs;
      x_e   = (m_k < 3 * PH) && (m_k % 3 == 1);
      x_nib = (m_k < 3 * PH) ? m_k / 3 : PH - 1;
      if (FOUR) x_db = (x_nib == 0) ? {m_d[7:4], 4'h0} : {m_d[3:0], 4'h0};
      else      x_db = m_d;
    end
  end

  // Every-cycle compare of all bus outputs against the model.
  always @(negedge clk) begin
    chk("cyc_in_ready", bus_if.in_ready, x_rdy);
    chk("cyc_lcd_e",    bus_if.lcd_e,    x_e);
    chk("cyc_lcd_rs",   bus_if.lcd_rs,   x_rs);
    chk("cyc_lcd_db",   bus_if.lcd_db,   x_db);
    chk("cyc_lcd_rw",   bus_if.lcd_rw,   1'b0);
  end

  // ---------------- directed writes ----------------
  task automatic write_measure(input logic [7:0] d, input logic rs, input bit scramble,
                               output int ticks, output int pulses, output int ecyc,
                               output logic [7:0] db0, output logic [7:0] dbl, output logic rs0);
    int start;
    bit ep;
    bit done;
    ticks = 0; pulses = 0; ecyc = 0; db0 = '0; dbl = '0; rs0 = 1'b0; ep = 1'b0; done = 1'b0;
    for (int i = 0; i < 5000 && !bus_if.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wr_idle_before", bus_if.in_ready, 1'b1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_rs    = rs;
    @(posedge clk);
    #1;
    start = n_ticks;
    if (!scramble) bus_if.in_valid = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (bus_if.lcd_e) begin
        if (!ep) begin
          pulses++;
          if (pulses == 1) begin
            db0 = bus_if.lcd_db;
            rs0 = bus_if.lcd_rs;
          end
          dbl = bus_if.lcd_db;
        end
        ecyc++;
      end
      ep = bus_if.lcd_e;
      if (bus_if.in_ready) begin
        done = 1'b1;
        break;
      end
      if (scramble) bus_if.in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    chk("wr_completes", done, 1'b1);
    ticks = n_ticks - start;
  endtask

  int         tk, np, ec;
  logic [7:0] d0, dl;
  logic       r0;

  logic [7:0] hd_data [6] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
  logic       hd_rs   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int         hd_hold [6] = '{LWT, WT, LWT, LWT, WT, WT};

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.in_rs    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_ready", bus_if.in_ready, 1'b1);
    chk("reset_e",     bus_if.lcd_e,    1'b0);
    chk("reset_db",    bus_if.lcd_db,   8'h00);
    repeat (40) @(posedge clk);
    #1;
    chk("idle_ready", bus_if.in_ready, 1'b1);

    // Data 0x41, RS=1.
    write_measure(8'h41, 1'b1, 1'b0, tk, np, ec, d0, dl, r0);
    chk("d41_ticks",  tk, 3 * PH + 3);
    chk("d41_pulses", np, PH);
    chk("d41_db",     d0, FOUR ? 8'h40 : 8'h41);
    chk("d41_rs",     r0, 1'b1);
    chk("d41_ehigh",  ec, 2 * DIV_HALF * PH);

    // Instruction 0x28 (function set).
    write_measure(8'h28, 1'b0, 1'b0, tk, np, ec, d0, dl, r0);
    chk("i28_pulses", np, PH);
    chk("i28_db_first", d0, FOUR ? 8'h20 : 8'h28);
    chk("i28_db_last",  dl, FOUR ? 8'h80 : 8'h28);
    chk("i28_rs",     r0, 1'b0);
    chk("i28_ticks",  tk, 3 * PH + 3);

    // Long vs short hold-off selection.
    for (int i = 0; i < 6; i++) begin
      write_measure(hd_data[i], hd_rs[i], 1'b0, tk, np, ec, d0, dl, r0);
      chk($sformatf("hold_%02h_rs%0d", hd_data[i], hd_rs[i]), tk, 3 * PH + hd_hold[i]);
    end

    // in_valid held with in_data changing throughout the write.
    write_measure(8'h55, 1'b1, 1'b1, tk, np, ec, d0, dl, r0);
    chk("hold_valid_db", d0, FOUR ? 8'h50 : 8'h55);
    chk("hold_valid_rs", r0, 1'b1);
    chk("hold_valid_ticks", tk, 3 * PH + 3);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    chk("hold_valid_reaccept", bus_if.in_ready, 1'b0);

    // Reset while E is high.
    for (int i = 0; i < 5000 && !bus_if.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h33;
    bus_if.in_rs    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 200 && !bus_if.lcd_e; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_saw_e", bus_if.lcd_e, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_e_low",  bus_if.lcd_e,    1'b0);
    chk("rst_ready",  bus_if.in_ready, 1'b1);
    chk("rst_db_low", bus_if.lcd_db,   8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    write_measure(8'h48, 1'b1, 1'b0, tk, np, ec, d0, dl, r0);
    chk("after_rst_ticks",  tk, 3 * PH + 3);
    chk("after_rst_db",     d0, FOUR ? 8'h40 : 8'h48);
    chk("after_rst_pulses", np, PH);

    repeat (20) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
